// File: rtl/fp_wb_pkg.sv
// Shared widths and requester ids for the FP writeback arbiter.
package fp_wb_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NREGS      = 2 ** ADDR_WIDTH;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;
endpackage

// File: rtl/fp_wb_slot.sv
// One-entry holding slot for a writeback requester; a beat to r0 is accepted and dropped.
module fp_wb_slot #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  grant,
  output logic                  ready,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);
  // Ready looks only at slot state and the grant, never at in_valid.
  assign ready = !full || grant;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (in_valid && ready && in_addr != '0) begin
      full <= 1'b1;
      addr <= in_addr;
      data <= in_data;
    end else if (grant) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/fp_wb_arbiter.sv
// Round-robin arbiter of FPU and FP-load writebacks onto the FP regfile port, plus busy scoreboard.
module fp_wb_arbiter #(
  parameter int DATA_WIDTH = fp_wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fp_wb_pkg::ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  A_Valid,
  output logic                  A_Ready,
  input  logic [ADDR_WIDTH-1:0] A_Addr,
  input  logic [DATA_WIDTH-1:0] A_Data,
  input  logic                  B_Valid,
  output logic                  B_Ready,
  input  logic [ADDR_WIDTH-1:0] B_Addr,
  input  logic [DATA_WIDTH-1:0] B_Data,
  input  logic                  Iss_Valid,
  input  logic [ADDR_WIDTH-1:0] Iss_Addr,
  input  logic [ADDR_WIDTH-1:0] Chk_Addr1,
  input  logic [ADDR_WIDTH-1:0] Chk_Addr2,
  output logic                  Busy1,
  output logic                  Busy2,
  output logic                  W_WE,
  output logic [ADDR_WIDTH-1:0] W_Addr,
  output logic [DATA_WIDTH-1:0] W_Din
);
  import fp_wb_pkg::*;

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [1:0]                 valid_in, ready, full, grant;
  logic [1:0][ADDR_WIDTH-1:0] addr_in, slot_addr;
  logic [1:0][DATA_WIDTH-1:0] data_in, slot_data;
  req_id_e                    ptr_q;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic [NUM_REGS-1:0]        busy_q, busy_d;

  assign valid_in = {B_Valid, A_Valid};
  assign addr_in  = {B_Addr, A_Addr};
  assign data_in  = {B_Data, A_Data};
  assign A_Ready  = ready[0];
  assign B_Ready  = ready[1];

  for (genvar i = 0; i < 2; i++) begin : g_slot
    fp_wb_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_slot (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .in_valid (valid_in[i]),
      .in_addr  (addr_in[i]),
      .in_data  (data_in[i]),
      .grant    (grant[i]),
      .ready    (ready[i]),
      .full     (full[i]),
      .addr     (slot_addr[i]),
      .data     (slot_data[i])
    );
  end

  always_comb begin
    grant = '0;
    if (full[0] && (!full[1] || ptr_q == REQ_A)) grant[0] = 1'b1;
    else if (full[1])                            grant[1] = 1'b1;
  end

  assign sel_addr = grant[1] ? slot_addr[1] : slot_addr[0];
  assign sel_data = grant[1] ? slot_data[1] : slot_data[0];

  // Pointer moves to the loser only when both slots competed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_q  <= REQ_A;
      W_WE   <= 1'b0;
      W_Addr <= '0;
      W_Din  <= '0;
    end else begin
      W_WE <= |grant;
      if (|grant) begin
        W_Addr <= sel_addr;
        W_Din  <= sel_data;
      end
      if (&full) ptr_q <= (ptr_q == REQ_A) ? REQ_B : REQ_A;
    end
  end

  // Issue is applied after writeback so a same-edge set keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (W_WE)      busy_d[W_Addr]   = 1'b0;
    if (Iss_Valid) busy_d[Iss_Addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign Busy1 = busy_q[Chk_Addr1];
  assign Busy2 = busy_q[Chk_Addr2];
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Table-driven bench for fp_wb_arbiter with a per-requester write scoreboard.
module tb_fp_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NV = 35;

  logic          Clk, Rst_n;
  logic          A_Valid, A_Ready, B_Valid, B_Ready;
  logic [AW-1:0] A_Addr, B_Addr, Iss_Addr, Chk_Addr1, Chk_Addr2, W_Addr;
  logic [DW-1:0] A_Data, B_Data, W_Din;
  logic          Iss_Valid, Busy1, Busy2, W_WE;

  fp_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Addr(A_Addr), .A_Data(A_Data),
    .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Addr(B_Addr), .B_Data(B_Data),
    .Iss_Valid(Iss_Valid), .Iss_Addr(Iss_Addr),
    .Chk_Addr1(Chk_Addr1), .Chk_Addr2(Chk_Addr2), .Busy1(Busy1), .Busy2(Busy2),
    .W_WE(W_WE), .W_Addr(W_Addr), .W_Din(W_Din)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          iv;
    logic [AW-1:0] ia;
    logic [AW-1:0] c1, c2;
    logic          e_ar, e_br, e_we;
    logic [AW-1:0] e_wa;
    logic          e_b1, e_b2;
  } vec_t;

  vec_t                   tbl [NV];
  logic [AW+DW-1:0]       qa[$], qb[$];
  int                     n_vec = 0;
  int                     n_err = 0;
  logic [31:0]            tb_busy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t row(input logic av, input int aa, input logic bv, input int ba,
                               input logic iv, input int ia, input int c1,
                               input logic ear, input logic ebr, input logic ewe, input int ewa,
                               input logic eb1, input logic eb2);
    vec_t v;
    v.av = av; v.aa = AW'(aa); v.ad = '0;
    v.bv = bv; v.ba = AW'(ba); v.bd = '0;
    v.iv = iv; v.ia = AW'(ia); v.c1 = AW'(c1); v.c2 = AW'(9);
    v.e_ar = ear; v.e_br = ebr; v.e_we = ewe; v.e_wa = AW'(ewa);
    v.e_b1 = eb1; v.e_b2 = eb2;
    return v;
  endfunction

  // Scoreboard: each observed write must match the oldest pending beat of A or B.
  always @(negedge Clk) begin : mon
    logic [AW+DW-1:0] got, exp;
    if (Rst_n && W_WE) begin
      got = {W_Addr, W_Din};
      exp = 'x;
      if (qa.size() > 0 && qa[0] == got)      exp = qa.pop_front();
      else if (qb.size() > 0 && qb[0] == got) exp = qb.pop_front();
      else if (qa.size() > 0)                 exp = qa.pop_front();
      else if (qb.size() > 0)                 exp = qb.pop_front();
      chk("sb write", 64'(got), 64'(exp));
    end
  end

  // Issuing to a register that still awaits writeback is illegal.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) tb_busy <= '0;
    else begin
      if (Iss_Valid && Iss_Addr != '0 && tb_busy[Iss_Addr])
        $display("WARN illegal WAW issue to r%0d", Iss_Addr);
      if (W_WE) tb_busy[W_Addr] <= 1'b0;
      if (Iss_Valid && Iss_Addr != '0) tb_busy[Iss_Addr] <= 1'b1;
    end
  end

  task automatic apply(input int i);
    vec_t v;
    v = tbl[i];
    A_Valid = v.av; A_Addr = v.aa; A_Data = v.ad;
    B_Valid = v.bv; B_Addr = v.ba; B_Data = v.bd;
    Iss_Valid = v.iv; Iss_Addr = v.ia; Chk_Addr1 = v.c1; Chk_Addr2 = v.c2;
    @(negedge Clk);
    chk($sformatf("r%0d A_Ready", i), 64'(A_Ready), 64'(v.e_ar));
    chk($sformatf("r%0d B_Ready", i), 64'(B_Ready), 64'(v.e_br));
    chk($sformatf("r%0d W_WE", i), 64'(W_WE), 64'(v.e_we));
    if (v.e_we) chk($sformatf("r%0d W_Addr", i), 64'(W_Addr), 64'(v.e_wa));
    chk($sformatf("r%0d Busy1", i), 64'(Busy1), 64'(v.e_b1));
    chk($sformatf("r%0d Busy2", i), 64'(Busy2), 64'(v.e_b2));
    if (v.av && v.e_ar && v.aa != '0) qa.push_back({v.aa, v.ad});
    if (v.bv && v.e_br && v.ba != '0) qb.push_back({v.ba, v.bd});
    @(posedge Clk); #1;
  endtask

  initial begin
    //                av aa bv ba iv ia c1   ar br we wa b1 b2
    tbl[0]  = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[1]  = row(1, 3, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[2]  = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[3]  = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 1, 3, 0, 0);
    tbl[4]  = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[5]  = row(1, 5, 1, 6, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[6]  = row(1, 5, 1, 6, 0, 0, 7,  1, 0, 0, 0, 0, 0);
    tbl[7]  = row(1, 5, 1, 6, 0, 0, 7,  0, 1, 1, 5, 0, 0);
    tbl[8]  = row(1, 5, 1, 6, 0, 0, 7,  1, 0, 1, 6, 0, 0);
    tbl[9]  = row(1, 5, 1, 6, 0, 0, 7,  0, 1, 1, 5, 0, 0);
    tbl[10] = row(0, 0, 0, 0, 0, 0, 7,  1, 0, 1, 6, 0, 0);
    tbl[11] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 1, 5, 0, 0);
    tbl[12] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 1, 6, 0, 0);
    tbl[13] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[14] = row(0, 0, 0, 0, 1, 7, 7,  1, 1, 0, 0, 0, 0);
    tbl[15] = row(0, 0, 1, 7, 0, 0, 7,  1, 1, 0, 0, 1, 0);
    tbl[16] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 1, 0);
    tbl[17] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 1, 7, 1, 0);
    tbl[18] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[19] = row(1, 9, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[20] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[21] = row(0, 0, 0, 0, 1, 9, 7,  1, 1, 1, 9, 0, 0);
    tbl[22] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 1);
    tbl[23] = row(1, 9, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 1);
    tbl[24] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 1);
    tbl[25] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 1, 9, 0, 1);
    tbl[26] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    tbl[27] = row(1, 0, 0, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[28] = row(0, 0, 1, 12, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[29] = row(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    tbl[30] = row(1, 10, 1, 11, 0, 0, 7, 1, 1, 1, 12, 0, 0);
    tbl[31] = row(0, 0, 0, 0, 0, 0, 7,  0, 1, 0, 0, 0, 0);
    tbl[32] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 1, 11, 0, 0);
    tbl[33] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 1, 10, 0, 0);
    tbl[34] = row(0, 0, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0);
    for (int i = 0; i < NV; i++) begin
      tbl[i].ad = 32'hA000_0000 | DW'(i);
      tbl[i].bd = 32'hB000_0000 | DW'(i);
    end
    tbl[1].ad = 32'h3F80_0000;

    Rst_n = 1'b0;
    A_Valid = 0; A_Addr = '0; A_Data = '0;
    B_Valid = 0; B_Addr = '0; B_Data = '0;
    Iss_Valid = 0; Iss_Addr = '0; Chk_Addr1 = '0; Chk_Addr2 = '0;
    #22 Rst_n = 1'b1;
    #1;
    chk("reset W_WE", 64'(W_WE), 64'd0);
    chk("reset W_Addr", 64'(W_Addr), 64'd0);
    chk("reset W_Din", 64'(W_Din), 64'd0);
    @(posedge Clk); #1;

    for (int i = 0; i < NV; i++) apply(i);

    // Reset with both slots full and a write on the port.
    A_Valid = 1; A_Addr = 5'd13; A_Data = 32'hC000_0001;
    B_Valid = 1; B_Addr = 5'd14; B_Data = 32'hC000_0002;
    Iss_Valid = 1; Iss_Addr = 5'd15; Chk_Addr1 = 5'd15;
    @(posedge Clk); #1;
    A_Data = 32'hC000_0003; B_Data = 32'hC000_0004; Iss_Valid = 0;
    @(negedge Clk);
    chk("rst busy15 set", 64'(Busy1), 64'd1);
    @(posedge Clk); #1;
    A_Valid = 0; B_Valid = 0;
    #1;
    chk("pre-rst W_WE", 64'(W_WE), 64'd1);
    chk("pre-rst W_Addr", 64'(W_Addr), 64'd13);
    chk("pre-rst A_Ready", 64'(A_Ready), 64'd0);
    chk("pre-rst B_Ready", 64'(B_Ready), 64'd1);
    Rst_n = 1'b0;
    #1;
    chk("rst W_WE", 64'(W_WE), 64'd0);
    chk("rst W_Addr", 64'(W_Addr), 64'd0);
    chk("rst W_Din", 64'(W_Din), 64'd0);
    chk("rst Busy1", 64'(Busy1), 64'd0);
    chk("rst A_Ready", 64'(A_Ready), 64'd1);
    chk("rst B_Ready", 64'(B_Ready), 64'd1);
    @(posedge Clk); #3;
    Rst_n = 1'b1;
    A_Valid = 1; A_Addr = 5'd3; A_Data = 32'h4000_0000;
    qa.push_back({5'd3, 32'h4000_0000});
    @(negedge Clk);
    chk("post-rst c0 W_WE", 64'(W_WE), 64'd0);
    @(posedge Clk); #1;
    A_Valid = 0;
    @(negedge Clk);
    chk("post-rst c1 W_WE", 64'(W_WE), 64'd0);
    chk("post-rst Busy1", 64'(Busy1), 64'd0);
    @(negedge Clk);
    chk("post-rst c2 W_WE", 64'(W_WE), 64'd1);
    chk("post-rst c2 W_Addr", 64'(W_Addr), 64'd3);
    @(negedge Clk);
    chk("post-rst c3 W_WE", 64'(W_WE), 64'd0);

    chk("qa drained", 64'(qa.size()), 64'd0);
    chk("qb drained", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_wb_arbiter.md
FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, FP register data width; ADDR_WIDTH, default 5, register address width (2**ADDR_WIDTH registers).
REQ-002 Clk  in  1  sole clock; all state SHALL change on posedge Clk.
REQ-003 Rst_n  in  1  reset, asynchronous, active-low.
REQ-004 A_Valid  in  1  FPU result write request; A_Ready  out  1  request accepted when A_Valid&A_Ready at posedge.
REQ-005 A_Addr  in  ADDR_WIDTH  destination register; A_Data  in  DATA_WIDTH  result value.
REQ-006 B_Valid/B_Ready/B_Addr/B_Data SHALL mirror A_* for the FP load unit.
REQ-007 Iss_Valid  in  1  instruction issue with FP destination; Iss_Addr  in  ADDR_WIDTH  its destination register.
REQ-008 Chk_Addr1, Chk_Addr2  in  ADDR_WIDTH  source registers to hazard-check; Busy1, Busy2  out  1  pending-write flag for each.
REQ-009 W_WE  out  1, W_Addr  out  ADDR_WIDTH, W_Din  out  DATA_WIDTH  SHALL drive the FP register file write port directly.

Function
REQ-010 Each requester SHALL own a 1-entry holding slot; Ready SHALL be 1 when its slot is empty or the slot is granted this cycle (full-throughput, one beat per cycle per requester when uncontended).
REQ-011 Ready SHALL not depend combinationally on Valid of the same requester.
REQ-012 Accepted requests with Addr==0 SHALL be consumed normally but never produce W_WE.
REQ-013 Each cycle at most one full slot SHALL be granted; only one full -> it wins; both full -> the requester named by the round-robin pointer wins.
REQ-014 Pointer SHALL toggle to the losing requester after every contended grant; uncontended grants SHALL leave it unchanged.
REQ-015 Latency: request accepted at edge k SHALL, if granted in cycle k..k+1, appear as W_WE=1 with its Addr/Data in cycle k+1..k+2 (registered outputs); regfile writes at edge k+2.
REQ-016 W_WE SHALL be 0 in any cycle following a cycle with no grant; W_Addr/W_Din SHALL hold last values when W_WE=0.
REQ-017 Both requesters targeting the same address SHALL be written in arbitration order, no merging.
REQ-018 Scoreboard: one busy bit per register; bit 0 SHALL be constant 0.
REQ-019 Iss_Valid at edge SHALL set busy[Iss_Addr]; W_WE=1 at edge SHALL clear busy[W_Addr].
REQ-020 Set and clear of the same address at the same edge SHALL leave the bit set.
REQ-021 Busy1/Busy2 SHALL be combinational reads of registered busy bits; no same-cycle bypass of a write in flight.
REQ-022 Issue to an already-busy register is illegal (WAW); the bench SHALL flag it; RTL keeps a single bit, cleared by the first writeback.

Reset
REQ-023 Rst_n low SHALL immediately empty both slots, set pointer to A, clear all busy bits, force W_WE=0, W_Addr=0, W_Din=0, A_Ready=B_Ready=1 after release.
REQ-024 Reset mid-operation SHALL discard buffered requests; no partial write SHALL reach W_WE after Rst_n deasserts.
REQ-025 First grant SHALL be possible at the first posedge after Rst_n rises.

Structure
REQ-026 Package fp_wb_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, NREGS=2**ADDR_WIDTH and the requester-id enum {REQ_A, REQ_B}.
REQ-027 Sub-module fp_wb_slot (1-entry valid/addr/data holding slot with Ready logic) SHALL be instantiated once per requester; arbiter and scoreboard stay in the top.

Verification
REQ-028 Reset then A_Valid=1, A_Addr=3, A_Data=32'h3F800000 one cycle -> W_WE=1, W_Addr=3, W_Din=32'h3F800000 exactly two cycles later, W_WE=0 otherwise.
REQ-029 A and B both valid every cycle, addrs 5 and 6 -> W_Addr alternates 5,6,5,6 (A first after reset); each Ready toggles at half rate.
REQ-030 Iss_Valid, Iss_Addr=7; Chk_Addr1=7 -> Busy1=1 next cycle; B writes 7 -> Busy1=0 in the cycle after W_WE(7).
REQ-031 Iss_Addr=9 at the same edge W_WE writes 9 -> Busy for 9 remains 1.
REQ-032 A_Addr=0 request -> A_Ready=1, no W_WE; Iss_Addr=0 -> Busy stays 0.
REQ-033 Both slots full, Rst_n pulsed low mid-cycle -> W_WE=0 immediately, no write of buffered data after release, all Busy=0.
